redirect_arbiter: RTL

REDIRECT_ARBITER -- requirements
Module: redirect_arbiter

---
 rtl/redirect_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/redirect_arbiter.sv
// Redirect arbiter: picks the oldest redirect request each cycle, issues it one cycle
// later, and filters out younger requests while a mispredict flush is in progress.
module redirect_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int SQN_W   = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       IN_req,
  input  logic [NUM_SRC*SQN_W-1:0] IN_sqN,
  input  logic [NUM_SRC*32-1:0]    IN_target,
  input  logic [NUM_SRC*5-1:0]     IN_fetchID,
  input  logic [NUM_SRC*16-1:0]    IN_hist,
  input  logic                     IN_flushDone,
  output logic                     OUT_redirValid,
  output logic [SQN_W-1:0]         OUT_sqN,
  output logic [31:0]              OUT_target,
  output logic [4:0]               OUT_fetchID,
  output logic [15:0]              OUT_hist,
  output logic [1:0]               OUT_src,
  output logic                     OUT_busy,
  output logic [7:0]               OUT_dropCnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SQN_W-1:0] last_sqn_q, last_sqn_d;
  logic             redir_valid_q, redir_valid_d;
  logic [SQN_W-1:0] sqn_q, sqn_d;
  logic [31:0]      target_q, target_d;
  logic [4:0]       fetch_id_q, fetch_id_d;
  logic [15:0]      hist_q, hist_d;
  logic [1:0]       src_q, src_d;
  logic             busy_q, busy_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [NUM_SRC-1:0] eligible;
  logic               win_found;
  logic [1:0]         win_idx;
  logic [SQN_W-1:0]   win_sqn;
  logic [7:0]         req_cnt;
  logic [7:0]         drop_inc;
  logic [8:0]         drop_sum;
  logic [SQN_W-1:0]   src_sqn;

  // Wrap-aware age compare: a is older than b when (a - b) is negative in SQN_W bits.
  function automatic logic is_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] diff;
    diff = a - b;
    return diff[SQN_W-1];
  endfunction

  always_comb begin
    eligible  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_sqn   = '0;
    req_cnt   = '0;
    src_sqn   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_sqn     = IN_sqN[i*SQN_W +: SQN_W];
      req_cnt     = req_cnt + 8'(IN_req[i]);
      eligible[i] = IN_req[i] &&
                    ((state_q == IDLE) || is_older(src_sqn, last_sqn_q));
      // Strictly-older replacement keeps the lowest index on equal sqN.
      if (eligible[i] && (!win_found || is_older(src_sqn, win_sqn))) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
        win_sqn   = src_sqn;
      end
    end
  end

  always_comb begin
    drop_inc = req_cnt - (win_found ? 8'd1 : 8'd0);
    drop_sum = {1'b0, drop_cnt_q} + {1'b0, drop_inc};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_d       = state_q;
    last_sqn_d    = last_sqn_q;
    redir_valid_d = 1'b0;
    sqn_d         = sqn_q;
    target_d      = target_q;
    fetch_id_d    = fetch_id_q;
    hist_d        = hist_q;
    src_d         = src_q;

    if (win_found) begin
      state_d       = FLUSH;
      last_sqn_d    = win_sqn;
      redir_valid_d = 1'b1;
      sqn_d         = win_sqn;
      target_d      = {IN_target[int'(win_idx)*32+1 +: 31], 1'b0};
      fetch_id_d    = IN_fetchID[int'(win_idx)*5 +: 5];
      hist_d        = IN_hist[int'(win_idx)*16 +: 16];
      src_d         = win_idx;
    end else if ((state_q == FLUSH) && IN_flushDone) begin
      state_d = IDLE;
    end

    busy_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_sqn_q    <= '0;
      redir_valid_q <= 1'b0;
      sqn_q         <= '0;
      target_q      <= '0;
      fetch_id_q    <= '0;
      hist_q        <= '0;
      src_q         <= '0;
      busy_q        <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_sqn_q    <= last_sqn_d;
      redir_valid_q <= redir_valid_d;
      sqn_q         <= sqn_d;
      target_q      <= target_d;
      fetch_id_q    <= fetch_id_d;
      hist_q        <= hist_d;
      src_q         <= src_d;
      busy_q        <= busy_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign OUT_redirValid = redir_valid_q;
  assign OUT_sqN        = sqn_q;
  assign OUT_target     = target_q;
  assign OUT_fetchID    = fetch_id_q;
  assign OUT_hist       = hist_q;
  assign OUT_src        = src_q;
  assign OUT_busy       = busy_q;
  assign OUT_dropCnt    = drop_cnt_q;

endmodule
